jls_stream_packer: RTL and testbench



---
 rtl/jls_pkg.sv | 47 ++++
 rtl/jls_bit_buffer.sv | 63 ++++++
 rtl/jls_stream_packer.sv | 212 +++++++++++++++++++++
 tb/tb_jls_stream_packer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jls_pkg.sv
// ---------------------------------------------------------------------------
// jls_pkg
// Shared definitions for the JPEG-LS stream packer:
//   - HDR_BYTES : the 25-byte SOI/SOF55/SOS header. Entries 7..10 are
//                 placeholders that are replaced by the latched frame height
//                 and width.
//   - MK_*      : marker byte constants.
//   - state_t   : packer FSM states.
//   - hdr_byte  : returns header byte idx with height/width substituted.
// ---------------------------------------------------------------------------
package jls_pkg;

    localparam int HDR_LEN = 25;

    localparam logic [7:0] MK_FF  = 8'hFF;
    localparam logic [7:0] MK_SOI = 8'hD8;
    localparam logic [7:0] MK_EOI = 8'hD9;

    localparam logic [7:0] HDR_BYTES [HDR_LEN] = '{
        8'hFF, 8'hD8, 8'hFF, 8'hF7, 8'h00, 8'h0B, 8'h08,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h01, 8'h01, 8'h11, 8'h00, 8'hFF, 8'hDA, 8'h00,
        8'h08, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_FLUSH,
        ST_EOI
    } state_t;

    // Height occupies bytes 7..8 and width bytes 9..10, both big-endian.
    function automatic logic [7:0] hdr_byte(input logic [4:0]  idx,
                                            input logic [15:0] width,
                                            input logic [15:0] height);
        case (idx)
            5'd7:    return height[15:8];
            5'd8:    return height[7:0];
            5'd9:    return width[15:8];
            5'd10:   return width[7:0];
            default: return (idx < 5'(HDR_LEN)) ? HDR_BYTES[idx] : 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/jls_bit_buffer.sv
// ---------------------------------------------------------------------------
// jls_bit_buffer
// MSB-aligned bit accumulator. Valid bits occupy the top `fill` positions of
// the register; every position below them is kept at zero, so the top byte
// is already zero-padded when fewer than 8 bits remain.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : discard all contents
//   push       : append the top push_bc bits of push_bv
//   push_bv/bc : payload (first bit at IN_W-1) and its valid-bit count
//   pop_n      : number of bits (0, 7 or 8) consumed from the top this cycle
//   top_byte   : the 8 oldest bits
//   fill       : number of valid bits held
// ---------------------------------------------------------------------------
module jls_bit_buffer #(
    parameter int IN_W   = 192,
    parameter int BUF_W  = 256,
    parameter int BC_W   = $clog2(IN_W + 1),
    parameter int FILL_W = $clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [IN_W-1:0]   push_bv,
    input  logic [BC_W-1:0]   push_bc,
    input  logic [3:0]        pop_n,
    output logic [7:0]        top_byte,
    output logic [FILL_W-1:0] fill
);

    logic [BUF_W-1:0]  bits;
    logic [BUF_W-1:0]  popped;
    logic [BUF_W-1:0]  appended;
    logic [IN_W-1:0]   masked;
    logic [FILL_W-1:0] fill_after_pop;

    // Pop first, then place the new bits directly behind what survives the
    // pop. Unused payload bits are masked off so the zero tail is preserved.
    always_comb begin
        popped         = bits << pop_n;
        fill_after_pop = fill - FILL_W'(pop_n);
        masked         = push_bv & ~({IN_W{1'b1}} >> push_bc);
        appended       = {masked, {(BUF_W-IN_W){1'b0}}} >> fill_after_pop;
    end

    // Buffer register: reset/clear empty it, otherwise pop and optional append.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bits <= '0;
            fill <= '0;
        end else if (push) begin
            bits <= popped | appended;
            fill <= fill_after_pop + FILL_W'(push_bc);
        end else begin
            bits <= popped;
            fill <= fill_after_pop;
        end
    end

    assign top_byte = bits[BUF_W-1 -: 8];

endmodule

// File: rtl/jls_stream_packer.sv
// ---------------------------------------------------------------------------
// jls_stream_packer
// Packs MSB-aligned variable-length bit vectors into a JPEG-LS byte stream:
// emits the header, data bytes with marker stuffing (a 0 bit is forced after
// every data 0xFF), a final partial byte and the EOI marker.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_sof, width, height: frame start (IDLE only) and image dimensions
//   i_vl/i_rdy          : input beat handshake
//   i_bv, i_bc, i_eof   : payload, valid-bit count, last beat of frame
//   o_vl/o_rdy          : output byte handshake
//   o_byte, o_last      : registered output byte, high with the 0xD9 byte
//   busy                : state is not IDLE
//   byte_cnt            : bytes transferred in the current frame
// ---------------------------------------------------------------------------
module jls_stream_packer
    import jls_pkg::*;
#(
    parameter int IN_W  = 192,
    parameter int BUF_W = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_sof,
    input  logic [15:0]                 width,
    input  logic [15:0]                 height,
    input  logic                        i_vl,
    input  logic [IN_W-1:0]             i_bv,
    input  logic [$clog2(IN_W+1)-1:0]   i_bc,
    input  logic                        i_eof,
    output logic                        i_rdy,
    output logic                        o_vl,
    output logic [7:0]                  o_byte,
    input  logic                        o_rdy,
    output logic                        o_last,
    output logic                        busy,
    output logic [31:0]                 byte_cnt
);

    localparam int BC_W   = $clog2(IN_W + 1);
    localparam int FILL_W = $clog2(BUF_W + 1);

    state_t            state, state_n;
    logic [4:0]        idx, idx_n;
    logic [15:0]       w_q, h_q;
    logic              prev_ff, prev_ff_n;
    logic              eof_seen, eof_seen_n;
    logic              load, load_last;
    logic [7:0]        load_byte;
    logic [3:0]        pop_n;
    logic              clr;
    logic              push;
    logic              out_free;
    logic [7:0]        top_byte;
    logic [7:0]        stuffed_byte;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] need;
    logic [FILL_W-1:0] space;

    jls_bit_buffer #(
        .IN_W  (IN_W),
        .BUF_W (BUF_W),
        .BC_W  (BC_W),
        .FILL_W(FILL_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .push    (push),
        .push_bv (i_bv),
        .push_bc (i_bc),
        .pop_n   (pop_n),
        .top_byte(top_byte),
        .fill    (fill)
    );

    // After a data 0xFF only 7 payload bits follow behind a forced 0 MSB.
    assign need         = prev_ff ? FILL_W'(7) : FILL_W'(8);
    assign stuffed_byte = prev_ff ? {1'b0, top_byte[7:1]} : top_byte;
    assign space        = FILL_W'(BUF_W) - fill;
    assign out_free     = !o_vl || o_rdy;
    assign i_rdy        = (state == ST_DATA) && !eof_seen && (space >= FILL_W'(IN_W));
    assign push         = i_vl && i_rdy;
    assign busy         = (state != ST_IDLE);

    // Next-state and output-register load decisions. idx counts header bytes
    // loaded in HDR and marker bytes loaded in EOI.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        prev_ff_n  = prev_ff;
        eof_seen_n = eof_seen;
        load       = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        pop_n      = 4'd0;
        clr        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_sof) begin
                    state_n   = ST_HDR;
                    load      = 1'b1;
                    load_byte = MK_FF;
                    idx_n     = 5'd1;
                end
            end
            ST_HDR: begin
                if (idx < 5'(HDR_LEN)) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_byte = hdr_byte(idx, w_q, h_q);
                        idx_n     = idx + 5'd1;
                    end
                end else if (o_vl && o_rdy) begin
                    state_n    = ST_DATA;
                    prev_ff_n  = 1'b0;
                    eof_seen_n = 1'b0;
                end
            end
            ST_DATA: begin
                if (push && i_eof) begin
                    eof_seen_n = 1'b1;
                end
                if (fill >= need) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_byte = stuffed_byte;
                        pop_n     = prev_ff ? 4'd7 : 4'd8;
                        prev_ff_n = (stuffed_byte == MK_FF);
                    end
                end else if (eof_seen) begin
                    state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fill != '0 || prev_ff) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_byte = stuffed_byte;
                        clr       = 1'b1;
                        state_n   = ST_EOI;
                        idx_n     = 5'd0;
                    end
                end else begin
                    state_n = ST_EOI;
                    idx_n   = 5'd0;
                end
            end
            ST_EOI: begin
                if (idx == 5'd0) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_byte = MK_FF;
                        idx_n     = 5'd1;
                    end
                end else if (idx == 5'd1) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_byte = MK_EOI;
                        load_last = 1'b1;
                        idx_n     = 5'd2;
                    end
                end else if (o_vl && o_rdy) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, frame parameters, output register and byte counter. The output
    // register only changes when a new byte is loaded or the current one is
    // consumed, so it holds steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            prev_ff  <= 1'b0;
            eof_seen <= 1'b0;
            o_vl     <= 1'b0;
            o_byte   <= 8'h00;
            o_last   <= 1'b0;
            byte_cnt <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            prev_ff  <= prev_ff_n;
            eof_seen <= eof_seen_n;
            if (state == ST_IDLE && i_sof) begin
                w_q      <= width;
                h_q      <= height;
                byte_cnt <= '0;
            end else if (o_vl && o_rdy) begin
                byte_cnt <= byte_cnt + 32'd1;
            end
            if (load) begin
                o_vl   <= 1'b1;
                o_byte <= load_byte;
                o_last <= load_last;
            end else if (o_rdy) begin
                o_vl   <= 1'b0;
                o_last <= 1'b0;
            end
        end
    end

    bc_legal: assert property (@(posedge clk) disable iff (rst)
                               i_vl |-> (i_bc <= BC_W'(IN_W)));

endmodule

// File: tb/tb_jls_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_jls_stream_packer
// Scoreboard bench: each frame's expected byte stream is computed by a
// software packer model and queued; a negedge monitor pops and compares every
// transferred byte, and checks that a stalled byte is held unchanged.
// ---------------------------------------------------------------------------
module tb_jls_stream_packer;

    localparam int IN_W  = 192;
    localparam int BUF_W = 256;
    localparam int BC_W  = $clog2(IN_W + 1);

    logic              clk;
    logic              rst;
    logic              i_sof;
    logic [15:0]       width;
    logic [15:0]       height;
    logic              i_vl;
    logic [IN_W-1:0]   i_bv;
    logic [BC_W-1:0]   i_bc;
    logic              i_eof;
    logic              i_rdy;
    logic              o_vl;
    logic [7:0]        o_byte;
    logic              o_rdy;
    logic              o_last;
    logic              busy;
    logic [31:0]       byte_cnt;

    int                checks;
    int                failures;
    int                cyc;
    int                hdr_rdy_err;
    int                hdr_first_cyc;
    int                hdr_last_cyc;
    int                xfer_idx;
    bit                sb_enable;
    bit                rdy_random;
    int                stretch_start;
    bit                stall_prev;
    logic [7:0]        prev_byte;
    logic              prev_last;

    logic [8:0]        exp_q[$];
    logic [IN_W-1:0]   bq_bv[$];
    int                bq_bc[$];

    jls_stream_packer #(.IN_W(IN_W), .BUF_W(BUF_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_sof   (i_sof),
        .width   (width),
        .height  (height),
        .i_vl    (i_vl),
        .i_bv    (i_bv),
        .i_bc    (i_bc),
        .i_eof   (i_eof),
        .i_rdy   (i_rdy),
        .o_vl    (o_vl),
        .o_byte  (o_byte),
        .o_rdy   (o_rdy),
        .o_last  (o_last),
        .busy    (busy),
        .byte_cnt(byte_cnt)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Sink ready: constant high, or random 50% with a 10-cycle low stretch.
    always @(posedge clk) begin
        #1;
        if (rdy_random && cyc >= stretch_start && cyc < stretch_start + 10)
            o_rdy = 1'b0;
        else if (rdy_random)
            o_rdy = 1'($urandom_range(0, 1));
        else
            o_rdy = 1'b1;
    end

    // Monitor: compares transferred bytes against the scoreboard, checks the
    // output is held while stalled, and that i_rdy stays low in the header.
    always @(negedge clk) begin
        if (rst) begin
            xfer_idx   = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                checkOutput("stall_hold", {22'd0, o_vl, o_last, o_byte},
                            {22'd0, 1'b1, prev_last, prev_byte});
            if (busy && xfer_idx < 25 && i_rdy)
                hdr_rdy_err++;
            if (o_vl && o_rdy) begin
                if (xfer_idx == 0)  hdr_first_cyc = cyc;
                if (xfer_idx == 24) hdr_last_cyc  = cyc;
                if (sb_enable) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_byte actual=%0h expected=none",
                                 {o_last, o_byte});
                    end else begin
                        checkOutput("stream_byte", {23'd0, o_last, o_byte},
                                    {23'd0, exp_q.pop_front()});
                    end
                end
                xfer_idx = o_last ? 0 : xfer_idx + 1;
            end
            stall_prev = o_vl && !o_rdy;
            prev_byte  = o_byte;
            prev_last  = o_last;
        end
    end

    // Software packer: header, greedy 8/7-bit extraction over the whole
    // concatenated bit string, final padded byte, then FF D9.
    function automatic int buildExpected(input logic [15:0] w, input logic [15:0] h);
        logic       bits[$];
        logic [7:0] hb [0:24];
        logic [7:0] byte_v;
        logic       pff;
        int         need;
        int         total;
        hb = '{8'hFF, 8'hD8, 8'hFF, 8'hF7, 8'h00, 8'h0B, 8'h08, h[15:8], h[7:0],
               w[15:8], w[7:0], 8'h01, 8'h01, 8'h11, 8'h00, 8'hFF, 8'hDA, 8'h00,
               8'h08, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        total = 0;
        for (int i = 0; i < 25; i++) begin
            exp_q.push_back({1'b0, hb[i]});
            total++;
        end
        for (int b = 0; b < bq_bc.size(); b++)
            for (int k = 0; k < bq_bc[b]; k++)
                bits.push_back(bq_bv[b][IN_W-1-k]);
        pff = 1'b0;
        forever begin
            need = pff ? 7 : 8;
            if (bits.size() < need) break;
            byte_v = 8'h00;
            for (int k = 0; k < need; k++)
                byte_v[need-1-k] = bits.pop_front();
            exp_q.push_back({1'b0, byte_v});
            total++;
            pff = (byte_v == 8'hFF);
        end
        if (bits.size() > 0 || pff) begin
            byte_v = 8'h00;
            need   = bits.size();
            for (int k = 0; k < need; k++)
                byte_v[(pff ? 6 : 7) - k] = bits.pop_front();
            exp_q.push_back({1'b0, byte_v});
            total++;
        end
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'hD9});
        return total + 2;
    endfunction

    function automatic logic [IN_W-1:0] randBv();
        logic [IN_W-1:0] v;
        for (int i = 0; i < IN_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Runs one full frame from the beat queues and checks its completion.
    task automatic applyStimulus(input logic [15:0] w, input logic [15:0] h,
                                 input int exp_cnt, input bit gaps);
        int total;
        int guard;
        int nbeats;
        bit aborted;
        total   = buildExpected(w, h);
        nbeats  = bq_bc.size();
        aborted = 1'b0;
        @(posedge clk); #1;
        width  = w;
        height = h;
        i_sof  = 1'b1;
        @(posedge clk); #1;
        i_sof  = 1'b0;
        width  = 16'($urandom);
        height = 16'($urandom);
        checkOutput("sof_latency", {23'd0, o_vl, o_byte}, {23'd0, 1'b1, 8'hFF});
        for (int b = 0; b < nbeats && !aborted; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_vl = 1'b0;
                @(posedge clk); #1;
            end
            i_vl  = 1'b1;
            i_bv  = bq_bv[b];
            i_bc  = BC_W'(bq_bc[b]);
            i_eof = (b == nbeats - 1);
            guard = 0;
            while (!i_rdy && guard < 5000) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!i_rdy) begin
                checks++;
                failures++;
                $display("[TB] FAIL beat_accept_timeout actual=i_rdy_low required=i_rdy_high");
                aborted = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (bq_bc[b] > BUF_W - IN_W + 8)
                    checkOutput("rdy_drop", {31'd0, i_rdy}, 32'd0);
            end
            i_vl  = 1'b0;
            i_eof = 1'b0;
        end
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 50000) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("frame_pending", exp_q.size(), 0);
        checkOutput("frame_busy", {31'd0, busy}, 32'd0);
        checkOutput("byte_cnt_model", byte_cnt, total);
        if (exp_cnt >= 0)
            checkOutput("byte_cnt_const", byte_cnt, exp_cnt);
        checkOutput("hdr_irdy_low", hdr_rdy_err, 0);
        exp_q.delete();
        bq_bv.delete();
        bq_bc.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_o_vl"},     {31'd0, o_vl},   32'd0);
        checkOutput({tag, "_o_byte"},   {24'd0, o_byte}, 32'd0);
        checkOutput({tag, "_o_last"},   {31'd0, o_last}, 32'd0);
        checkOutput({tag, "_i_rdy"},    {31'd0, i_rdy},  32'd0);
        checkOutput({tag, "_busy"},     {31'd0, busy},   32'd0);
        checkOutput({tag, "_byte_cnt"}, byte_cnt,        32'd0);
    endtask

    initial begin
        logic [IN_W-1:0] v;
        int              guard;
        checks        = 0;
        failures      = 0;
        hdr_rdy_err   = 0;
        hdr_first_cyc = 0;
        hdr_last_cyc  = 0;
        xfer_idx      = 0;
        stall_prev    = 1'b0;
        sb_enable     = 1'b1;
        rdy_random    = 1'b0;
        stretch_start = -100;
        rst    = 1'b1;
        i_sof  = 1'b0;
        width  = '0;
        height = '0;
        i_vl   = 1'b0;
        i_bv   = '0;
        i_bc   = '0;
        i_eof  = 1'b0;
        o_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkReset("reset");

        // Header plus stuffing: 16 ones -> FF 7F 80, then FF D9.
        v = '0;
        v[IN_W-1 -: 16] = 16'hFFFF;
        bq_bv.push_back(v); bq_bc.push_back(16);
        applyStimulus(16'd256, 16'd256, 30, 1'b0);
        checkOutput("hdr_rate", hdr_last_cyc - hdr_first_cyc, 24);

        // Flush after FF: 8 ones -> FF 00, then FF D9.
        v = '0;
        v[IN_W-1 -: 8] = 8'hFF;
        bq_bv.push_back(v); bq_bc.push_back(8);
        applyStimulus(16'd640, 16'd480, 29, 1'b0);

        // Aligned end: A5 then an empty eof beat.
        v = '0;
        v[IN_W-1 -: 8] = 8'hA5;
        bq_bv.push_back(v); bq_bc.push_back(8);
        bq_bv.push_back(randBv()); bq_bc.push_back(0);
        applyStimulus(16'd17, 16'd3, 28, 1'b0);

        // Reset in the middle of DATA, then a fresh frame.
        sb_enable = 1'b0;
        @(posedge clk); #1;
        i_sof = 1'b1; width = 16'd99; height = 16'd77;
        @(posedge clk); #1;
        i_sof = 1'b0;
        i_vl  = 1'b1; i_bv = randBv(); i_bc = BC_W'(150); i_eof = 1'b0;
        guard = 0;
        while (!i_rdy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("mid_reset_reach_data", {31'd0, i_rdy}, 32'd1);
        @(posedge clk); #1;
        i_vl = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkReset("mid_reset");
        exp_q.delete();
        sb_enable = 1'b1;
        v = '0;
        v[IN_W-1 -: 12] = 12'hABC;
        bq_bv.push_back(v); bq_bc.push_back(12);
        applyStimulus(16'h1234, 16'h5678, 29, 1'b0);

        // Random beats with random sink backpressure and a 10-cycle stall.
        rdy_random    = 1'b1;
        stretch_start = cyc + 300;
        for (int b = 0; b < 400; b++) begin
            bq_bv.push_back(randBv());
            bq_bc.push_back((b % 37 == 5) ? IN_W : $urandom_range(0, IN_W));
        end
        applyStimulus(16'd256, 16'd256, -1, 1'b1);

        // A second, shorter random frame with small beats (more FF runs).
        for (int b = 0; b < 120; b++) begin
            v = randBv();
            if ($urandom_range(0, 1) == 1) v[IN_W-1 -: 32] = 32'hFFFF_FFFF;
            bq_bv.push_back(v);
            bq_bc.push_back($urandom_range(0, 40));
        end
        applyStimulus(16'($urandom), 16'($urandom), -1, 1'b1);
        rdy_random = 1'b0;

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
